snake_dir_queue_ctrl: RTL and testbench

- Next-generation snake direction controller for N independent players (channels).
- Each channel conditions raw buttons (2-FF sync, debounce, rising-edge detect), validates turns against the snake's planned heading, and buffers valid turns in a small per-channel FIFO.
- Buffered turns are applied one per move tick, so fast two-key combos (e.g. up then left) are not lost between ticks.
- Sits between board switches/buttons and the snake movement/body-update logic.

---
 rtl/snake_pkg.sv | 21 ++
 rtl/snake_dir_queue_ctrl_if.sv | 25 ++
 rtl/snake_btn_debounce.sv | 54 +++++
 rtl/snake_dir_queue_ctrl.sv | 98 +++++++++
 tb/tb_snake_dir_queue_ctrl.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared direction types, button indices and axis helper
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_UP    = 2'b11
    } dir_t;

    localparam int BTN_RIGHT = 0;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_UP    = 3;

    // Bit 1 selects the vertical axis, so a turn is legal only when it flips that bit.
    function automatic logic same_axis(input dir_t a, input dir_t b);
        return a[1] == b[1];
    endfunction

endpackage

// File: rtl/snake_dir_queue_ctrl_if.sv
// rtl/snake_dir_queue_ctrl_if.sv - button/tick inputs and per-channel heading outputs
interface snake_dir_queue_ctrl_if #(
    parameter int N_CH        = 2,
    parameter int QUEUE_DEPTH = 2
);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);

    logic [4*N_CH-1:0]  btn;
    logic               move_tick;
    logic               run;
    logic [2*N_CH-1:0]  dir;
    logic [N_CH-1:0]    started;
    logic [N_CH*CW-1:0] q_count;
    logic [N_CH-1:0]    overflow;

    modport master (
        output btn, move_tick, run,
        input  dir, started, q_count, overflow
    );

    modport slave (
        input  btn, move_tick, run,
        output dir, started, q_count, overflow
    );
endinterface

// File: rtl/snake_btn_debounce.sv
// rtl/snake_btn_debounce.sv - 2-FF sync, stable-count debounce and registered press pulse
module snake_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);
    localparam int CNTW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic            sync1, sync2;
    logic            level, level_d;
    logic            fill1, fill2;
    logic            armed;
    logic [CNTW-1:0] cnt;

    // armed stays low until the button has been seen released after reset,
    // so a button held through reset never produces a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            fill1   <= 1'b0;
            fill2   <= 1'b0;
            armed   <= 1'b0;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            fill1   <= 1'b1;
            fill2   <= fill1;
            level_d <= level;
            if (fill2 && !sync2 && !level) begin
                armed <= 1'b1;
            end
            if (sync2 != level) begin
                if (cnt == CNTW'(DEBOUNCE_CYCLES - 1)) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CNTW'(1);
                end
            end else begin
                cnt <= '0;
            end
            press <= armed & level & ~level_d;
        end
    end

endmodule

// File: rtl/snake_dir_queue_ctrl.sv
// rtl/snake_dir_queue_ctrl.sv - per-channel turn validation, turn FIFO and tick-driven heading update
module snake_dir_queue_ctrl
    import snake_pkg::*;
#(
    parameter int   N_CH            = 2,
    parameter int   QUEUE_DEPTH     = 2,
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter dir_t INIT_DIR        = DIR_RIGHT
) (
    input logic                  clk,
    input logic                  rst,
    snake_dir_queue_ctrl_if.slave bus
);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam int AW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

    logic [4*N_CH-1:0] press_all;

    for (genvar i = 0; i < 4*N_CH; i++) begin : g_btn
        snake_btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk  (clk),
            .rst  (rst),
            .raw  (bus.btn[i]),
            .press(press_all[i])
        );
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        dir_t          q_mem [QUEUE_DEPTH];
        logic [AW-1:0] wr_ptr, rd_ptr;
        logic [CW-1:0] count;
        dir_t          cur_dir, plan, sel_dir;
        logic [3:0]    pr;
        logic          sel_valid, full, push, drop, pop;
        logic          started_r, overflow_r;

        assign pr   = press_all[4*c +: 4];
        assign full = (count == CW'(QUEUE_DEPTH));
        // Validate against where the snake will be heading once the queue drains.
        assign plan = (count != '0) ? q_mem[wr_ptr - AW'(1)] : cur_dir;

        always_comb begin
            sel_valid = 1'b0;
            sel_dir   = cur_dir;
            if (pr[BTN_DOWN] && !same_axis(DIR_DOWN, plan)) begin
                sel_valid = 1'b1;
                sel_dir   = DIR_DOWN;
            end else if (pr[BTN_UP] && !same_axis(DIR_UP, plan)) begin
                sel_valid = 1'b1;
                sel_dir   = DIR_UP;
            end else if (pr[BTN_RIGHT] && !same_axis(DIR_RIGHT, plan)) begin
                sel_valid = 1'b1;
                sel_dir   = DIR_RIGHT;
            end else if (pr[BTN_LEFT] && !same_axis(DIR_LEFT, plan)) begin
                sel_valid = 1'b1;
                sel_dir   = DIR_LEFT;
            end
        end

        assign push = bus.run & sel_valid & ~full;
        assign drop = bus.run & sel_valid & full;
        // Pop decision uses the pre-push count, so a fresh entry in an empty queue survives this tick.
        assign pop  = bus.run & bus.move_tick & (count != '0);

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count      <= '0;
                cur_dir    <= INIT_DIR;
                started_r  <= 1'b0;
                overflow_r <= 1'b0;
            end else begin
                if (push) begin
                    q_mem[wr_ptr] <= sel_dir;
                    wr_ptr        <= wr_ptr + AW'(1);
                    started_r     <= 1'b1;
                end
                if (drop) begin
                    overflow_r <= 1'b1;
                end
                if (pop) begin
                    cur_dir <= q_mem[rd_ptr];
                    rd_ptr  <= rd_ptr + AW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end

        assign bus.dir[2*c +: 2]      = cur_dir;
        assign bus.started[c]         = started_r;
        assign bus.overflow[c]        = overflow_r;
        assign bus.q_count[CW*c +: CW] = count;
    end

endmodule

// File: tb/tb_snake_dir_queue_ctrl.sv
// tb/tb_snake_dir_queue_ctrl.sv - table-driven and scoreboard checks for snake_dir_queue_ctrl
module tb_snake_dir_queue_ctrl;
    localparam int N_CH = 2;
    localparam int QD   = 2;
    localparam int CW   = $clog2(QD + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    snake_dir_queue_ctrl_if #(.N_CH(N_CH), .QUEUE_DEPTH(QD)) bus ();

    snake_dir_queue_ctrl #(
        .N_CH(N_CH), .QUEUE_DEPTH(QD), .DEBOUNCE_CYCLES(4), .INIT_DIR(snake_pkg::DIR_RIGHT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int         ch;
        logic [3:0] btns;
        int         exp_cnt;
        logic [1:0] exp_dir;
    } vec_t;

    typedef struct {
        int         ch;
        logic [1:0] d;
    } sb_t;

    int         n_total = 0;
    int         n_pass  = 0;
    sb_t        sb[$];
    logic [1:0] held_dir [N_CH];
    vec_t       vecs [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    endtask

    function automatic int qcnt(input int ch);
        return int'(bus.q_count[CW*ch +: CW]);
    endfunction

    function automatic int hdir(input int ch);
        return int'(bus.dir[2*ch +: 2]);
    endfunction

    task automatic do_reset();
        bus.btn = '0; bus.move_tick = 1'b0; bus.run = 1'b1;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        sb.delete();
        for (int c = 0; c < N_CH; c++) held_dir[c] = 2'b00;
        repeat (5) step();
    endtask

    task automatic press(input int ch, input logic [3:0] b);
        bus.btn[4*ch +: 4] = b;
        repeat (8) step();
        bus.btn[4*ch +: 4] = 4'b0000;
        repeat (8) step();
    endtask

    task automatic expect_push(input int ch, input logic [1:0] d);
        sb_t e;
        e.ch = ch; e.d = d;
        sb.push_back(e);
    endtask

    task automatic tick_check(input string name, input int ch);
        bus.move_tick = 1'b1;
        step();
        bus.move_tick = 1'b0;
        if (sb.size() > 0 && sb[0].ch == ch) begin
            sb_t e;
            e = sb.pop_front();
            held_dir[ch] = e.d;
        end
        chk(name, hdir(ch), int'(held_dir[ch]));
    endtask

    initial begin
        vecs[0] = '{0, 4'b0001, 0, 2'b00};
        vecs[1] = '{0, 4'b0010, 0, 2'b00};
        vecs[2] = '{0, 4'b0100, 1, 2'b10};
        vecs[3] = '{0, 4'b1000, 1, 2'b11};
        vecs[4] = '{1, 4'b1100, 1, 2'b10};
        vecs[5] = '{1, 4'b0101, 1, 2'b10};
        vecs[6] = '{1, 4'b1010, 1, 2'b11};
        vecs[7] = '{0, 4'b1111, 1, 2'b10};

        do_reset();
        repeat (50) step();
        chk("reset_dir", int'(bus.dir), 0);
        chk("reset_started", int'(bus.started), 0);
        chk("reset_qcount", int'(bus.q_count), 0);
        chk("reset_overflow", int'(bus.overflow), 0);

        // exact press-to-enqueue latency on a clean down press
        do_reset();
        bus.btn[2] = 1'b1;
        repeat (7) step();
        chk("lat_before", qcnt(0), 0);
        step();
        chk("lat_at_k7", qcnt(0), 1);
        expect_push(0, 2'b10);
        bus.btn[2] = 1'b0;
        repeat (8) step();
        chk("lat_started", int'(bus.started[0]), 1);
        tick_check("lat_tick_dir", 0);
        chk("lat_tick_cnt", qcnt(0), 0);

        for (int i = 0; i < 8; i++) begin
            do_reset();
            press(vecs[i].ch, vecs[i].btns);
            chk($sformatf("vec%0d_cnt", i), qcnt(vecs[i].ch), vecs[i].exp_cnt);
            chk($sformatf("vec%0d_other", i), qcnt(1 - vecs[i].ch), 0);
            if (vecs[i].exp_cnt != 0) expect_push(vecs[i].ch, vecs[i].exp_dir);
            tick_check($sformatf("vec%0d_dir", i), vecs[i].ch);
        end

        // two-key combo survives between ticks
        do_reset();
        press(0, 4'b1000); expect_push(0, 2'b11);
        press(0, 4'b0010); expect_push(0, 2'b01);
        chk("combo_cnt", qcnt(0), 2);
        tick_check("combo_tick1", 0);
        tick_check("combo_tick2", 0);
        chk("combo_empty", qcnt(0), 0);

        // full queue drops the third turn
        do_reset();
        press(0, 4'b0100); expect_push(0, 2'b10);
        press(0, 4'b0010); expect_push(0, 2'b01);
        press(0, 4'b1000);
        chk("ovf_cnt", qcnt(0), 2);
        chk("ovf_flag", int'(bus.overflow), 1);
        tick_check("ovf_tick1", 0);
        tick_check("ovf_tick2", 0);

        // 3-cycle glitch on ch1 up never qualifies
        do_reset();
        bus.btn[7] = 1'b1;
        repeat (3) step();
        bus.btn[7] = 1'b0;
        repeat (20) step();
        chk("glitch_cnt", qcnt(1), 0);
        chk("glitch_started", int'(bus.started[1]), 0);

        // pause discards presses and ticks, then push+tick into empty queue
        do_reset();
        bus.run = 1'b0;
        press(0, 4'b0100);
        tick_check("pause_dir", 0);
        chk("pause_cnt", qcnt(0), 0);
        chk("pause_started", int'(bus.started[0]), 0);
        bus.run = 1'b1;
        bus.btn[2] = 1'b1;
        repeat (7) step();
        bus.move_tick = 1'b1;
        step();
        bus.move_tick = 1'b0;
        expect_push(0, 2'b10);
        chk("same_cyc_cnt", qcnt(0), 1);
        chk("same_cyc_dir", hdir(0), 0);
        bus.btn[2] = 1'b0;
        repeat (8) step();
        tick_check("same_cyc_next", 0);
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
